// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for the CPU datapath. A one-hot fetch/execute
//   state machine (RESET, T0..T7, HALT) is stepped by the opcode held in
//   the instruction register. Every datapath, register-file, memory and
//   ALU control strobe is a combinational decode of the state, ir and con.
//
// Ports
//   clk        rising-edge clock shared with the datapath
//   clr        asynchronous active-low reset
//   stop       halt request, taken only on the edge leaving an
//              instruction's last state
//   ir[31:0]   instruction register contents (op = ir[31:27])
//   con        branch-condition flag from the CONN_FF block
//   run        1 while executing, 0 in RESET or HALT
//   Gra..BAout register-file select / enable strobes
//   PCout..CONN_in  datapath strobes
//   read/write memory strobes
//   alu_op     ALU operation code
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        stop,
    input  logic [31:0] ir,
    input  logic        con,
    output logic        run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        incPC,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowOut,
    output logic        ZHighOut,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        InPortout,
    output logic        OutPortIn,
    output logic        CONN_in,
    output logic        read,
    output logic        write,
    output logic [4:0]  alu_op
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [9:0] {
        S_RESET = 10'b00_0000_0001,
        S_T0    = 10'b00_0000_0010,
        S_T1    = 10'b00_0000_0100,
        S_T2    = 10'b00_0000_1000,
        S_T3    = 10'b00_0001_0000,
        S_T4    = 10'b00_0010_0000,
        S_T5    = 10'b00_0100_0000,
        S_T6    = 10'b00_1000_0000,
        S_T7    = 10'b01_0000_0000,
        S_HALT  = 10'b10_0000_0000
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    state_t     end_state;
    logic [4:0] op;
    logic [2:0] last_t;
    logic       is_rfmt, is_imm, is_base;
    logic       is_muldiv, is_negnot;
    logic [4:0] imm_alu;
    logic       unused_ir;

    assign op        = ir[31:27];
    // Register fields are decoded by the datapath itself, not here.
    assign unused_ir = ^ir[26:0];

    assign is_rfmt   = (op >= OP_ADD)  && (op <= OP_ROL);
    assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
    // ld, ldi and st share the base-address + constant address calculation.
    assign is_base   = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_negnot = (op == OP_NEG) || (op == OP_NOT);

    always_comb begin
        unique case (op)
            OP_ADDI: imm_alu = OP_ADD;
            OP_ANDI: imm_alu = OP_AND;
            default: imm_alu = OP_OR;
        endcase
    end

    // Index of the final state of the current instruction (2 = fetch only).
    always_comb begin
        last_t = 3'd2;
        if (op == OP_LD || op == OP_ST)
            last_t = 3'd7;
        else if (is_muldiv || op == OP_BR)
            last_t = 3'd6;
        else if (is_rfmt || is_imm || op == OP_LDI)
            last_t = 3'd5;
        else if (is_negnot || op == OP_JAL)
            last_t = 3'd4;
        else if (op == OP_JR || op == OP_IN || op == OP_OUT ||
                 op == OP_MFHI || op == OP_MFLO)
            last_t = 3'd3;
    end

    // A stop request only takes effect at an instruction boundary.
    assign end_state = stop ? S_HALT : S_T0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state_reg <= S_RESET;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = S_RESET;
        unique case (state_reg)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2: begin
                if (op == OP_HALT)
                    state_next = S_HALT;
                else if (last_t == 3'd2)
                    state_next = end_state;
                else
                    state_next = S_T3;
            end
            S_T3:    state_next = (last_t == 3'd3) ? end_state : S_T4;
            S_T4:    state_next = (last_t == 3'd4) ? end_state : S_T5;
            S_T5:    state_next = (last_t == 3'd5) ? end_state : S_T6;
            S_T6:    state_next = (last_t == 3'd6) ? end_state : S_T7;
            S_T7:    state_next = end_state;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    always_comb begin
        run       = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        BAout     = 1'b0;
        PCout     = 1'b0;
        incPC     = 1'b0;
        PCin      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        ZLowOut   = 1'b0;
        ZHighOut  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        Cout      = 1'b0;
        InPortout = 1'b0;
        OutPortIn = 1'b0;
        CONN_in   = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        alu_op    = 5'b00000;
        if (state_reg != S_RESET && state_reg != S_HALT)
            run = 1'b1;
        unique case (state_reg)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; incPC = 1'b1;
            end
            S_T1: begin
                read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (is_rfmt || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_base) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_negnot) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
                end else if (op == OP_BR) begin
                    Gra = 1'b1; Rout = 1'b1; CONN_in = 1'b1;
                end else if (op == OP_JR) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (op == OP_JAL) begin
                    // Link register is selected through the Rb field.
                    PCout = 1'b1; Grb = 1'b1; Rin = 1'b1;
                end else if (op == OP_IN) begin
                    InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_OUT) begin
                    Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
                end else if (op == OP_MFHI) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_MFLO) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T4: begin
                if (is_rfmt) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu;
                end else if (is_base) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
                end else if (is_negnot) begin
                    ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_BR) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (op == OP_JAL) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end
            end
            S_T5: begin
                if (is_rfmt || is_imm || op == OP_LDI) begin
                    ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_LD || op == OP_ST) begin
                    ZLowOut = 1'b1; MARin = 1'b1;
                end else if (is_muldiv) begin
                    ZLowOut = 1'b1; LOin = 1'b1;
                end else if (op == OP_BR) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
                end
            end
            S_T6: begin
                if (op == OP_LD) begin
                    read = 1'b1; MDRin = 1'b1;
                end else if (op == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_muldiv) begin
                    ZHighOut = 1'b1; HIin = 1'b1;
                end else if (op == OP_BR && con) begin
                    // Branch target already sits in Z; only taken if con is set.
                    ZLowOut = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                if (op == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_ST) begin
                    write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed and random instruction streams for control_sequencer. A
//   reference model expands each instruction into the list of expected
//   per-cycle control words (fetch + execute steps), and every cycle the
//   DUT outputs are compared against the next entry of that list.
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic        stop;
    logic [31:0] ir;
    logic        con;
    logic        run;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        PCout, incPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin;
    logic        ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Cout;
    logic        InPortout, OutPortIn, CONN_in, read, write;
    logic [4:0]  alu_op;

    control_sequencer dut (
        .clk(clk), .clr(clr), .stop(stop), .ir(ir), .con(con), .run(run),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .incPC(incPC), .PCin(PCin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
        .OutPortIn(OutPortIn), .CONN_in(CONN_in), .read(read), .write(write),
        .alu_op(alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {run, alu_op, strobes[26:0]}
    localparam logic [26:0] M_GRA     = 27'd1 << 0;
    localparam logic [26:0] M_GRB     = 27'd1 << 1;
    localparam logic [26:0] M_GRC     = 27'd1 << 2;
    localparam logic [26:0] M_RIN     = 27'd1 << 3;
    localparam logic [26:0] M_ROUT    = 27'd1 << 4;
    localparam logic [26:0] M_BAOUT   = 27'd1 << 5;
    localparam logic [26:0] M_PCOUT   = 27'd1 << 6;
    localparam logic [26:0] M_INCPC   = 27'd1 << 7;
    localparam logic [26:0] M_PCIN    = 27'd1 << 8;
    localparam logic [26:0] M_MARIN   = 27'd1 << 9;
    localparam logic [26:0] M_MDRIN   = 27'd1 << 10;
    localparam logic [26:0] M_MDROUT  = 27'd1 << 11;
    localparam logic [26:0] M_IRIN    = 27'd1 << 12;
    localparam logic [26:0] M_YIN     = 27'd1 << 13;
    localparam logic [26:0] M_ZIN     = 27'd1 << 14;
    localparam logic [26:0] M_ZLOW    = 27'd1 << 15;
    localparam logic [26:0] M_ZHIGH   = 27'd1 << 16;
    localparam logic [26:0] M_HIIN    = 27'd1 << 17;
    localparam logic [26:0] M_LOIN    = 27'd1 << 18;
    localparam logic [26:0] M_HIOUT   = 27'd1 << 19;
    localparam logic [26:0] M_LOOUT   = 27'd1 << 20;
    localparam logic [26:0] M_COUT    = 27'd1 << 21;
    localparam logic [26:0] M_INPORT  = 27'd1 << 22;
    localparam logic [26:0] M_OUTPORT = 27'd1 << 23;
    localparam logic [26:0] M_CONNIN  = 27'd1 << 24;
    localparam logic [26:0] M_READ    = 27'd1 << 25;
    localparam logic [26:0] M_WRITE   = 27'd1 << 26;

    localparam logic [32:0] IDLE_WORD = 33'd0;

    logic [32:0] obs;
    assign obs = {run, alu_op, write, read, CONN_in, OutPortIn, InPortout, Cout,
                  LOout, HIout, LOin, HIin, ZHighOut, ZLowOut, Zin, Yin, IRin,
                  MDRout, MDRin, MARin, PCin, incPC, PCout, BAout, Rout, Rin,
                  Grc, Grb, Gra};

    int tests_run = 0;
    int tests_failed = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] expv);
        tests_run++;
        assert (got === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic push(input logic [26:0] m, input logic [4:0] a);
        exp_q.push_back({1'b1, a, m});
    endtask

    // Reference model: expected control word for every cycle of one instruction.
    task automatic build(input logic [31:0] w, input logic c);
        int op;
        op = int'(w[31:27]);
        push(M_PCOUT | M_MARIN | M_INCPC, 5'd0);
        push(M_READ | M_MDRIN, 5'd0);
        push(M_MDROUT | M_IRIN, 5'd0);
        if (op >= 3 && op <= 11) begin
            push(M_GRB | M_ROUT | M_YIN, 5'd0);
            push(M_GRC | M_ROUT | M_ZIN, 5'(op));
            push(M_ZLOW | M_GRA | M_RIN, 5'd0);
        end else if (op >= 12 && op <= 14) begin
            push(M_GRB | M_ROUT | M_YIN, 5'd0);
            push(M_COUT | M_ZIN, (op == 12) ? 5'd3 : (op == 13) ? 5'd5 : 5'd6);
            push(M_ZLOW | M_GRA | M_RIN, 5'd0);
        end else if (op == 1) begin
            push(M_GRB | M_BAOUT | M_YIN, 5'd0);
            push(M_COUT | M_ZIN, 5'd3);
            push(M_ZLOW | M_GRA | M_RIN, 5'd0);
        end else if (op == 0 || op == 2) begin
            push(M_GRB | M_BAOUT | M_YIN, 5'd0);
            push(M_COUT | M_ZIN, 5'd3);
            push(M_ZLOW | M_MARIN, 5'd0);
            if (op == 0) begin
                push(M_READ | M_MDRIN, 5'd0);
                push(M_MDROUT | M_GRA | M_RIN, 5'd0);
            end else begin
                push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
                push(M_WRITE, 5'd0);
            end
        end else if (op == 15 || op == 16) begin
            push(M_GRA | M_ROUT | M_YIN, 5'd0);
            push(M_GRB | M_ROUT | M_ZIN, 5'(op));
            push(M_ZLOW | M_LOIN, 5'd0);
            push(M_ZHIGH | M_HIIN, 5'd0);
        end else if (op == 17 || op == 18) begin
            push(M_GRB | M_ROUT | M_ZIN, 5'(op));
            push(M_ZLOW | M_GRA | M_RIN, 5'd0);
        end else if (op == 19) begin
            push(M_GRA | M_ROUT | M_CONNIN, 5'd0);
            push(M_PCOUT | M_YIN, 5'd0);
            push(M_COUT | M_ZIN, 5'd3);
            push(c ? (M_ZLOW | M_PCIN) : 27'd0, 5'd0);
        end else if (op == 20) begin
            push(M_GRA | M_ROUT | M_PCIN, 5'd0);
        end else if (op == 21) begin
            push(M_PCOUT | M_GRB | M_RIN, 5'd0);
            push(M_GRA | M_ROUT | M_PCIN, 5'd0);
        end else if (op == 22) begin
            push(M_INPORT | M_GRA | M_RIN, 5'd0);
        end else if (op == 23) begin
            push(M_GRA | M_ROUT | M_OUTPORT, 5'd0);
        end else if (op == 24) begin
            push(M_HIOUT | M_GRA | M_RIN, 5'd0);
        end else if (op == 25) begin
            push(M_LOOUT | M_GRA | M_RIN, 5'd0);
        end
        // nop, halt and 28..31: fetch only
    endtask

    // Entered just after the edge that puts the DUT in T0. Returns just after
    // the edge leaving the final state, or at the negedge of step abort_at.
    task automatic run_instr(input string name, input logic [31:0] w, input logic c,
                             input int stop_at, input int abort_at);
        logic [32:0] e;
        int n;
        exp_q.delete();
        build(w, c);
        ir  = w;
        con = c;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s.t%0d", name, i), obs, e);
            if (i == abort_at) return;
            if (i == stop_at) stop = 1'b1;
            @(posedge clk);
            #1;
        end
        $display("[TB] instr %-10s ir=%h con=%0d cycles=%0d", name, w, c, n);
    endtask

    task automatic halt_hold(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s.c%0d", name, i), obs, IDLE_WORD);
        end
    endtask

    // Async reset applied mid-cycle, checked before any clock edge.
    task automatic do_reset(input string name);
        #1 clr = 1'b0;
        #1 check($sformatf("%s.async", name), obs, IDLE_WORD);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("%s.hold%0d", name, i), obs, IDLE_WORD);
        end
        stop = 1'b0;
        clr  = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] reset %s released", name);
    endtask

    logic [31:0] rnd_w;
    logic        rnd_c;

    initial begin
        clr  = 1'b1;
        stop = 1'b0;
        ir   = 32'd0;
        con  = 1'b0;
        @(posedge clk);
        do_reset("power_on");

        run_instr("add",   32'h18918000, 1'b0, -1, -1);
        run_instr("ld",    32'h00900055, 1'b1, -1, -1);
        run_instr("br_c1", 32'h99000010, 1'b1, -1, -1);
        run_instr("br_c0", 32'h99000010, 1'b0, -1, -1);
        run_instr("mul",   32'h79A00000, 1'b0, -1, -1);
        run_instr("nop",   32'hD0000000, 1'b0, -1, -1);
        run_instr("nop31", 32'hF8000000, 1'b0, -1, -1);

        for (int k = 0; k < 60; k++) begin
            rnd_w = $urandom();
            if (rnd_w[31:27] == 5'd27)
                rnd_w[31:27] = 5'd26;
            rnd_c = 1'($urandom_range(0, 1));
            run_instr($sformatf("rnd%0d", k), rnd_w, rnd_c, -1, -1);
        end

        // Reset landing in the middle of ld (T5).
        run_instr("ld_abort", 32'h00900055, 1'b0, -1, 5);
        do_reset("mid_ld");
        run_instr("add_post", 32'h18918000, 1'b0, -1, -1);

        // stop raised in add T3: instruction completes, then HALT.
        run_instr("add_stop", 32'h18918000, 1'b0, 3, -1);
        halt_hold("add_stop_halt", 5);
        do_reset("after_stop");

        // stop on a fetch-only instruction ends at T2.
        run_instr("nop_stop", 32'hD0000000, 1'b0, 0, -1);
        halt_hold("nop_stop_halt", 3);
        do_reset("after_nop");

        run_instr("halt", 32'hD8000000, 1'b0, -1, -1);
        halt_hold("halt_hold", 100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
